// File: rtl/fxp8s_pe_seq.sv
// Sequencer for a 3x3 fxp8s matrix-multiply PE array: streams A then B from
// operand memory into the array, then drains the 9 results back to memory.
module fxp8s_pe_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] a_addr,
   input  logic [7:0] b_addr,
   input  logic [7:0] c_addr,
   output logic       busy,
   output logic       done,
   output logic       mem_rd_en,
   output logic [7:0] mem_rd_addr,
   input  logic [7:0] mem_rd_data,
   output logic       mem_wr_en,
   output logic [7:0] mem_wr_addr,
   output logic [7:0] mem_wr_data,
   output logic       pe_en_in,
   input  logic       pe_rdy_in,
   output logic       pe_in_mat,
   output logic [7:0] pe_in_data,
   input  logic       pe_en_out,
   output logic       pe_rdy_out,
   input  logic [7:0] pe_out_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_SEND,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [4:0] NUM_A     = 5'd9;
   localparam logic [4:0] LAST_IDX  = 5'd17;
   localparam logic [3:0] LAST_OIDX = 4'd8;

   state_t     state_q, state_d;
   logic [4:0] idx_q, idx_d;
   logic [3:0] oidx_q, oidx_d;
   logic [7:0] hold_q, hold_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [7:0] c_q, c_d;

   logic       is_b;
   logic [4:0] rd_off;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= 5'd0;
         oidx_q  <= 4'd0;
         hold_q  <= 8'h00;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         c_q     <= 8'h00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         oidx_q  <= oidx_d;
         hold_q  <= hold_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
      end
   end

   // Elements 0..8 come from A, 9..17 from B; offsets wrap modulo 256.
   assign is_b   = (idx_q >= NUM_A);
   assign rd_off = is_b ? (idx_q - NUM_A) : idx_q;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      oidx_d      = oidx_q;
      hold_d      = hold_q;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      busy        = (state_q != S_IDLE);
      done        = 1'b0;
      mem_rd_en   = 1'b0;
      mem_rd_addr = (is_b ? b_q : a_q) + {3'b000, rd_off};
      mem_wr_en   = 1'b0;
      mem_wr_addr = c_q + {4'h0, oidx_q};
      mem_wr_data = pe_out_data;
      pe_en_in    = 1'b0;
      pe_in_mat   = is_b;
      pe_in_data  = hold_q;
      pe_rdy_out  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RD;
               idx_d   = 5'd0;
               oidx_d  = 4'd0;
               a_d     = a_addr;
               b_d     = b_addr;
               c_d     = c_addr;
            end
         end
         S_RD: begin
            mem_rd_en = 1'b1;
            state_d   = S_CAP;
         end
         S_CAP: begin
            hold_d  = mem_rd_data;
            state_d = S_SEND;
         end
         S_SEND: begin
            pe_en_in = 1'b1;
            // idx stays at 17 after the final element; it is cleared on the next start.
            if (pe_rdy_in) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_DRAIN;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = S_RD;
               end
            end
         end
         S_DRAIN: begin
            pe_rdy_out = 1'b1;
            if (pe_en_out) begin
               mem_wr_en = 1'b1;
               if (oidx_q == LAST_OIDX) begin
                  state_d = S_DONE;
               end else begin
                  oidx_d = oidx_q + 4'd1;
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Reset takes effect on the strobes in the same cycle, so an abort never
      // lets a last write or transfer slip out before the state register clears.
      if (rst) begin
         busy       = 1'b0;
         done       = 1'b0;
         mem_rd_en  = 1'b0;
         mem_wr_en  = 1'b0;
         pe_en_in   = 1'b0;
         pe_rdy_out = 1'b0;
      end
   end

endmodule

// File: tb/tb_fxp8s_pe_seq.sv
// Randomized bench: memory and PE-array behavioural models plus a matrix-level
// reference that predicts read order, streamed elements and written results.
module tb_fxp8s_pe_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a_addr = 8'h00, b_addr = 8'h00, c_addr = 8'h00;
   logic       busy, done;
   logic       mem_rd_en, mem_wr_en;
   logic [7:0] mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data;
   logic       pe_en_in, pe_rdy_in, pe_in_mat;
   logic [7:0] pe_in_data;
   logic       pe_en_out, pe_rdy_out;
   logic [7:0] pe_out_data;

   fxp8s_pe_seq dut (
      .clk(clk), .rst(rst), .start(start),
      .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
      .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .pe_en_in(pe_en_in), .pe_rdy_in(pe_rdy_in), .pe_in_mat(pe_in_mat),
      .pe_in_data(pe_in_data), .pe_en_out(pe_en_out), .pe_rdy_out(pe_rdy_out),
      .pe_out_data(pe_out_data)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [256];
   int          n_chk = 0, n_err = 0;
   logic [7:0]  rd_q[$];
   logic [7:0]  in_d_q[$];
   logic        in_m_q[$];
   logic [15:0] wr_q[$];
   logic [7:0]  out_q[$];
   int          done_cnt = 0;
   bit          rd_pend = 0;
   logic [7:0]  rd_addr_l = 8'h00;
   int          rdy_pct = 100, en_pct = 100, stall_elem = -1, stall_cnt = 0;
   bit          early = 0;
   bit          stall_prev = 0;
   logic [7:0]  prev_data = 8'h00;
   logic        prev_mat = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Monitor: records every transaction as seen at the upcoming rising edge.
   initial forever begin
      @(negedge clk);
      if (mem_rd_en) begin
         rd_q.push_back(mem_rd_addr);
         rd_pend   = 1;
         rd_addr_l = mem_rd_addr;
      end
      if (mem_wr_en) begin
         chk("wr_handshake", {31'b0, pe_en_out & pe_rdy_out}, 1);
         chk("rd_wr_overlap", {31'b0, mem_rd_en}, 0);
         wr_q.push_back({mem_wr_addr, mem_wr_data});
      end
      if (stall_prev && !rst) begin
         chk("stall_en", {31'b0, pe_en_in}, 1);
         chk("stall_data", {24'b0, pe_in_data}, {24'b0, prev_data});
         chk("stall_mat", {31'b0, pe_in_mat}, {31'b0, prev_mat});
         chk("stall_rd", {31'b0, mem_rd_en}, 0);
      end
      stall_prev = !rst && pe_en_in && !pe_rdy_in;
      prev_data  = pe_in_data;
      prev_mat   = pe_in_mat;
      if (!rst && pe_en_in && pe_rdy_in) begin
         in_d_q.push_back(pe_in_data);
         in_m_q.push_back(pe_in_mat);
         // PE array model: C = A*B in fxp8s, products summed then scaled by 2^-4.
         if (in_d_q.size() == 18) begin
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++) begin
                  int s, av, bv;
                  s = 0;
                  for (int k = 0; k < 3; k++) begin
                     av = $signed(in_d_q[i*3+k]);
                     bv = $signed(in_d_q[9+k*3+j]);
                     s += av * bv;
                  end
                  out_q.push_back(8'(s >>> 4));
               end
         end
      end
      if (pe_en_out && pe_rdy_out && out_q.size() != 0) void'(out_q.pop_front());
      if (done) done_cnt++;
      if (rst) begin
         in_d_q.delete(); in_m_q.delete(); out_q.delete(); rd_pend = 0;
      end
   end

   // Memory read port and PE handshake responder, driven just after each rising edge.
   initial begin
      pe_rdy_in = 1'b0; pe_en_out = 1'b0; pe_out_data = 8'h00; mem_rd_data = 8'h00;
      forever begin
         @(posedge clk); #1;
         mem_rd_data = rd_pend ? mem[rd_addr_l] : 8'($urandom);
         rd_pend = 0;
         if (pe_en_in && int'(in_d_q.size()) == stall_elem && stall_cnt < 5) begin
            pe_rdy_in = 1'b0;
            stall_cnt++;
         end else begin
            pe_rdy_in = (int'($urandom_range(0, 99)) < rdy_pct);
         end
         if (out_q.size() != 0) begin
            pe_en_out   = (int'($urandom_range(0, 99)) < en_pct);
            pe_out_data = out_q[0];
         end else begin
            pe_en_out   = early;
            pe_out_data = 8'($urandom);
         end
      end
   end

   task automatic fill_mem(input logic [7:0] a, input logic [7:0] b, input bit nominal);
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      if (nominal)
         for (int k = 0; k < 9; k++) begin
            mem[8'(a + k)] = 8'h08;
            mem[8'(b + k)] = (k % 4 == 0) ? 8'h08 : 8'h00;
         end
   endtask

   // Called just after a rising edge; returns at a falling edge with the job running.
   task automatic start_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      rd_q.delete(); in_d_q.delete(); in_m_q.delete(); wr_q.delete(); out_q.delete();
      done_cnt = 0; stall_cnt = 0;
      start = 1'b1; a_addr = a; b_addr = b; c_addr = c;
      @(negedge clk);
      chk("busy_pre", {31'b0, busy}, 0);
      @(posedge clk); #1;
      start = 1'b0; a_addr = 8'($urandom); b_addr = 8'($urandom); c_addr = 8'($urandom);
      @(negedge clk);
      chk("busy_post", {31'b0, busy}, 1);
   endtask

   task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input bit nominal, input int busy_start_cyc, input bit start_in_done);
      bit          got_done;
      logic [7:0]  ea;
      logic [15:0] w;
      logic [7:0]  expc [9];
      fill_mem(a, b, nominal);
      start_job(a, b, c);
      got_done = 0;
      for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
         @(posedge clk); #1;
         if (cyc == busy_start_cyc) begin
            start = 1'b1; a_addr = 8'($urandom); b_addr = 8'($urandom); c_addr = 8'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (done) got_done = 1;
      end
      chk("job_done", {31'b0, got_done}, 1);
      chk("done_busy", {31'b0, busy}, {31'b0, got_done});
      if (start_in_done) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      @(negedge clk);
      chk("idle_after_done", {31'b0, busy}, 0);
      repeat (4) @(negedge clk);
      chk("idle_stays", {31'b0, busy}, 0);
      chk("done_count", done_cnt, 1);
      chk("rd_count", rd_q.size(), 18);
      chk("in_count", in_d_q.size(), 18);
      chk("wr_count", wr_q.size(), 9);
      for (int k = 0; k < 18; k++) begin
         ea = (k < 9) ? 8'(a + k) : 8'(b + k - 9);
         if (k < rd_q.size()) chk("rd_addr", {24'b0, rd_q[k]}, {24'b0, ea});
         if (k < in_d_q.size()) begin
            chk("in_data", {24'b0, in_d_q[k]}, {24'b0, mem[ea]});
            chk("in_mat", {31'b0, in_m_q[k]}, {31'b0, k >= 9});
         end
      end
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            int s, av, bv;
            s = 0;
            for (int k = 0; k < 3; k++) begin
               av = $signed(mem[8'(a + i*3 + k)]);
               bv = $signed(mem[8'(b + k*3 + j)]);
               s += av * bv;
            end
            expc[i*3+j] = 8'(s >>> 4);
         end
      for (int k = 0; k < 9; k++)
         if (k < wr_q.size()) begin
            w = wr_q[k];
            chk("wr_addr", {24'b0, w[15:8]}, {24'b0, 8'(c + k)});
            chk("wr_data", {24'b0, w[7:0]}, {24'b0, expc[k]});
            if (nominal) chk("nom_wr_data", {24'b0, w[7:0]}, 32'h04);
         end
      @(posedge clk); #1;
   endtask

   task automatic mid_drain_reset();
      int waited;
      fill_mem(8'($urandom), 8'($urandom), 0);
      start_job(8'($urandom), 8'($urandom), 8'($urandom));
      waited = 0;
      while (wr_q.size() < 4 && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      chk("mid_reach_4wr", wr_q.size(), 4);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_wr_en", {31'b0, mem_wr_en}, 0);
      chk("mid_busy", {31'b0, busy}, 0);
      chk("mid_done", {31'b0, done}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_no_more_wr", wr_q.size(), 4);
      chk("mid_no_done", done_cnt, 0);
      chk("mid_idle", {31'b0, busy}, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_rd_en", {31'b0, mem_rd_en}, 0);
      chk("rst_wr_en", {31'b0, mem_wr_en}, 0);
      chk("rst_pe_en_in", {31'b0, pe_en_in}, 0);
      chk("rst_pe_rdy_out", {31'b0, pe_rdy_out}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      // nominal job, start in the very first cycle out of reset
      run_job(8'h00, 8'h10, 8'h20, 1, -1, 0);
      // input stall at element 4, outputs offered early and gapped
      stall_elem = 4; early = 1; en_pct = 50;
      run_job(8'($urandom), 8'($urandom), 8'($urandom), 0, -1, 0);
      chk("forced_stall", stall_cnt, 5);
      stall_elem = -1; early = 0; en_pct = 100;
      // address wrap on A and C, start held during DONE
      run_job(8'hFC, 8'h30, 8'hFB, 0, -1, 1);
      // second start during the job
      run_job(8'($urandom), 8'($urandom), 8'($urandom), 0, 10, 0);
      for (int r = 0; r < 4; r++) begin
         rdy_pct = 60; en_pct = 60; early = bit'($urandom_range(0, 1));
         run_job(8'($urandom), 8'($urandom), 8'($urandom), 0, -1, 0);
      end
      rdy_pct = 100; en_pct = 70; early = 1;
      mid_drain_reset();
      run_job(8'($urandom), 8'($urandom), 8'($urandom), 0, -1, 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
